dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one single-port synchronous data RAM between two requesters:
  - port 0: CPU load/store path.
  - port 1: host/loader port (program load, memory inspection).
- Two-state FSM: round-robin (or fixed-priority) arbitration, one RAM access per grant, one-cycle ack back to the winner.
- Supplies a stall to the CPU so the PC register holds until the CPU's access completes.

Parameters:
- ADDR_W, 11, word-address width of RAM and both request ports.
- DATA_W, 32, data width.
- RR_EN, 1: 1 = round-robin on simultaneous requests; 0 = port 0 always wins ties.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  CPU access request; held until p0_ack.
- p0_we  in  1  CPU write (1) / read (0).
- p0_addr  in  ADDR_W  CPU word address (byte address bits [ADDR_W+1:2]).
- p0_wdata  in  DATA_W  CPU store data.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  DATA_W  read data, valid while p0_ack=1.
- cpu_stall  out  1  = p0_req & ~p0_ack; drives PC-register enable low.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for the host.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0.
- busy  out  1  FSM in ACCESS.

Behaviour:
- States:
  - IDLE: evaluate requests.
    - If any req=1, choose winner, register winner index, go ACCESS.
    - In the same cycle, combinationally drive mem_en=1, mem_we, mem_addr and mem_wdata from the winner's inputs.
  - ACCESS:
    - mem_en=0, mem_we=0.
    - Assert winner's ack=1 for exactly this cycle; its rdata = mem_rdata; non-winner ack=0.
    - Set last_grant = winner. Always return to IDLE.
- Latency and throughput:
  - Request to ack = 1 cycle if uncontended.
  - One transaction per 2 cycles maximum.
  - Losing requester waits at least 2 extra cycles.
- Arbitration on simultaneous req:
  - RR_EN=1: winner = port not equal to last_grant.
  - RR_EN=0: port 0 wins.
  - Single requester always wins.
- Writes:
  - Data is in RAM at the edge ending the IDLE issue cycle.
  - Ack for a write still occurs in ACCESS; rdata is don't-care, driven as mem_rdata.
- Requester rules:
  - Hold req/we/addr/wdata stable from assertion through the ack cycle.
  - Inputs are sampled only in the IDLE issue cycle.
  - Requester may deassert or present a new request the cycle after ack; it is re-arbitrated in IDLE.
  - If req drops before ack, the in-flight access still completes and ack still pulses.
- Outputs:
  - Idle defaults: p*_ack=0, mem_en=0, mem_we=0.
  - mem_addr/mem_wdata = port-0 inputs when no grant.
  - p*_rdata = mem_rdata at all times (qualified by ack).
- Reset (synchronous, active-high):
  - state=IDLE, last_grant=1 (port 0 wins the first tie), winner=0.
  - All acks 0, mem_en=0, busy=0.
  - Reset asserted during ACCESS: no ack is issued; a write already issued is not undone.
- cpu_stall is combinational from p0_req and p0_ack: 1 during the p0 issue cycle and any wait cycles, 0 in p0's ack cycle.

Decomposition:
- Shared package holds:
  - state encoding (ST_IDLE=1'b0, ST_ACCESS=1'b1)
  - port index constants (PORT_CPU=0, PORT_HOST=1)
  - default widths
- One natural sub-module: rr_arbiter2, a 2-way round-robin picker (req[1:0], last_grant, rr_en -> grant index, any). Keeps the FSM module free of priority logic.

Test Plan:
1. Reset, then p0 write addr=0x010 data=0xDEADBEEF, p1 idle.
   - Issue cycle: mem_en=1, mem_we=1, mem_addr=0x010, cpu_stall=1.
   - Next cycle: p0_ack=1, cpu_stall=0, busy=1.
2. p0 read addr=0x010 after scenario 1 -> p0_ack one cycle after issue, p0_rdata=0xDEADBEEF, mem_we=0.
3. p0 and p1 request together from reset (p0 read 0x004, p1 write 0x008=0x12345678), RR_EN=1:
   - p0 granted first; ack at cycle 1.
   - p1 issued cycle 2, acked cycle 3.
   - cpu_stall=1 only in cycle 0.
4. Both hold req continuously for 8 cycles, RR_EN=1 -> acks alternate p0,p1,p0,p1 at cycles 1,3,5,7. With RR_EN=0 -> p0 acked at 1,3,5,7, p1 never.
5. Reset asserted in the ACCESS cycle of a p1 read -> p1_ack stays 0. Next cycle state=IDLE, busy=0. A tie then goes to p0.
6. p1 drops req during its ACCESS cycle -> p1_ack still pulses once; no second access is issued.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encoding, port indices and default widths
package dmem_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_HOST = 1'b1;
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter2: 2-way picker, round-robin or port-0 priority on ties
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       rr_en,
  output logic       grant,
  output logic       any
);
  always_comb begin
    any = |req;
    grant = &req ? (rr_en ? ~last_grant : PORT_CPU) : (req[1] ? PORT_HOST : PORT_CPU);
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port sync RAM between CPU and host ports
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              cpu_stall,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_t state, state_next;
  logic winner, last_grant, grant, any, issue;
  rr_arbiter2 u_arb (
    .req        ({p1_req, p0_req}),
    .last_grant (last_grant),
    .rr_en      (RR_EN),
    .grant      (grant),
    .any        (any)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      winner <= PORT_CPU;
      last_grant <= PORT_HOST;
    end else begin
      state <= state_next;
      if (issue) winner <= grant;
      if (state == ST_ACCESS) last_grant <= winner;
    end
  end
  // Outputs are gated by rst so a reset landing in ACCESS suppresses the ack
  always_comb begin
    issue = ~rst & (state == ST_IDLE) & any;
    state_next = issue ? ST_ACCESS : ST_IDLE;
    mem_en = issue;
    mem_we = issue & (grant ? p1_we : p0_we);
    mem_addr = issue & grant ? p1_addr : p0_addr;
    mem_wdata = issue & grant ? p1_wdata : p0_wdata;
    busy = ~rst & (state == ST_ACCESS);
    p0_ack = busy & (winner == PORT_CPU);
    p1_ack = busy & (winner == PORT_HOST);
    p0_rdata = mem_rdata;
    p1_rdata = mem_rdata;
    cpu_stall = p0_req & ~p0_ack;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized run against a reference model
module tb_dmem_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst;
  logic p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic a_p0_ack, a_p1_ack, a_stall, a_en, a_we, a_busy;
  logic b_p0_ack, b_p1_ack, b_stall, b_en, b_we, b_busy;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_p0_rdata, a_p1_rdata, a_wdata, a_rdata;
  logic [DW-1:0] b_p0_rdata, b_p1_rdata, b_wdata, b_rdata;
  logic [DW-1:0] ram_a [2**AW];
  logic [DW-1:0] ram_b [2**AW];
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata), .cpu_stall(a_stall),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
    .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_rdata(a_rdata), .busy(a_busy)
  );
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata), .cpu_stall(b_stall),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_rdata(b_rdata), .busy(b_busy)
  );
  always @(posedge clk) begin
    if (a_en) begin
      if (a_we) ram_a[a_addr] <= a_wdata;
      else a_rdata <= ram_a[a_addr];
    end
    if (b_en) begin
      if (b_we) ram_b[b_addr] <= b_wdata;
      else b_rdata <= ram_b[b_addr];
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle_inputs();
    rst = 1;
    next_cycle();
    next_cycle();
    rst = 0;
  endtask
  task automatic test_reset();
    idle_inputs();
    rst = 1;
    p0_req = 1;
    next_cycle();
    @(negedge clk);
    n_checks++; if (a_en !== 1'b0) begin n_errors++; $display("FAIL reset_mem_en: got %b want 0", a_en); end
    n_checks++; if ({a_p0_ack, a_p1_ack} !== 2'b00) begin n_errors++; $display("FAIL reset_acks: got %b want 00", {a_p0_ack, a_p1_ack}); end
    n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    next_cycle();
    p0_req = 0;
    rst = 0;
    @(negedge clk);
    n_checks++; if ({a_en, a_busy, a_stall} !== 3'b000) begin n_errors++; $display("FAIL reset_idle: en/busy/stall got %b want 000", {a_en, a_busy, a_stall}); end
    next_cycle();
  endtask
  task automatic test_write_read();
    do_reset();
    p0_req = 1; p0_we = 1; p0_addr = 11'h010; p0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++; if ({a_en, a_we, a_stall} !== 3'b111) begin n_errors++; $display("FAIL wr_issue: en/we/stall got %b want 111", {a_en, a_we, a_stall}); end
    n_checks++; if (a_addr !== 11'h010 || a_wdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wr_issue_bus: addr %h data %h want 010 deadbeef", a_addr, a_wdata); end
    next_cycle();
    @(negedge clk);
    n_checks++; if ({a_p0_ack, a_stall, a_busy, a_en} !== 4'b1010) begin n_errors++; $display("FAIL wr_ack: ack/stall/busy/en got %b want 1010", {a_p0_ack, a_stall, a_busy, a_en}); end
    next_cycle();
    p0_we = 0; p0_wdata = '0;
    @(negedge clk);
    n_checks++; if ({a_en, a_we} !== 2'b10) begin n_errors++; $display("FAIL rd_issue: en/we got %b want 10", {a_en, a_we}); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (a_p0_ack !== 1'b1) begin n_errors++; $display("FAIL rd_ack: got %b want 1", a_p0_ack); end
    n_checks++; if (a_p0_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_data: got %h want deadbeef", a_p0_rdata); end
    next_cycle();
    idle_inputs();
  endtask
  task automatic test_contention();
    do_reset();
    p0_req = 1; p0_we = 0; p0_addr = 11'h004;
    p1_req = 1; p1_we = 1; p1_addr = 11'h008; p1_wdata = 32'h12345678;
    @(negedge clk);
    n_checks++; if ({a_en, a_we, a_stall} !== 3'b101 || a_addr !== 11'h004) begin n_errors++; $display("FAIL tie_c0: en/we/stall %b addr %h want 101 004", {a_en, a_we, a_stall}, a_addr); end
    next_cycle();
    @(negedge clk);
    n_checks++; if ({a_p0_ack, a_p1_ack, a_stall} !== 3'b100) begin n_errors++; $display("FAIL tie_c1: ack0/ack1/stall got %b want 100", {a_p0_ack, a_p1_ack, a_stall}); end
    next_cycle();
    p0_req = 0;
    @(negedge clk);
    n_checks++; if ({a_en, a_we, a_stall} !== 3'b110 || a_addr !== 11'h008) begin n_errors++; $display("FAIL tie_c2: en/we/stall %b addr %h want 110 008", {a_en, a_we, a_stall}, a_addr); end
    next_cycle();
    @(negedge clk);
    n_checks++; if ({a_p0_ack, a_p1_ack, a_stall} !== 3'b010) begin n_errors++; $display("FAIL tie_c3: ack0/ack1/stall got %b want 010", {a_p0_ack, a_p1_ack, a_stall}); end
    n_checks++; if (ram_a[8] !== 32'h12345678) begin n_errors++; $display("FAIL tie_wr: ram got %h want 12345678", ram_a[8]); end
    next_cycle();
    idle_inputs();
  endtask
  task automatic test_back_to_back();
    do_reset();
    p0_req = 1; p0_addr = 11'h001;
    p1_req = 1; p1_addr = 11'h002;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++; if ({a_p0_ack, a_p1_ack} !== {c % 4 == 1, c % 4 == 3}) begin n_errors++; $display("FAIL b2b_rr c%0d: acks got %b want %b", c, {a_p0_ack, a_p1_ack}, {c % 4 == 1, c % 4 == 3}); end
      n_checks++; if ({b_p0_ack, b_p1_ack} !== {c % 2 == 1, 1'b0}) begin n_errors++; $display("FAIL b2b_fp c%0d: acks got %b want %b", c, {b_p0_ack, b_p1_ack}, {c % 2 == 1, 1'b0}); end
      n_checks++; if (a_stall !== (c % 4 != 1)) begin n_errors++; $display("FAIL b2b_stall c%0d: got %b want %b", c, a_stall, c % 4 != 1); end
      next_cycle();
    end
    idle_inputs();
  endtask
  task automatic test_reset_in_access();
    do_reset();
    p1_req = 1; p1_addr = 11'h008;
    @(negedge clk);
    n_checks++; if (a_en !== 1'b1 || a_addr !== 11'h008) begin n_errors++; $display("FAIL rsta_issue: en %b addr %h want 1 008", a_en, a_addr); end
    next_cycle();
    rst = 1;
    @(negedge clk);
    n_checks++; if ({a_p1_ack, b_p1_ack} !== 2'b00) begin n_errors++; $display("FAIL rsta_noack: got %b want 00", {a_p1_ack, b_p1_ack}); end
    next_cycle();
    rst = 0;
    p0_req = 1; p0_addr = 11'h003;
    @(negedge clk);
    n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL rsta_busy: got %b want 0", a_busy); end
    n_checks++; if (a_en !== 1'b1 || a_addr !== 11'h003) begin n_errors++; $display("FAIL rsta_tie: en %b addr %h want 1 003", a_en, a_addr); end
    next_cycle();
    @(negedge clk);
    n_checks++; if ({a_p0_ack, a_p1_ack} !== 2'b10) begin n_errors++; $display("FAIL rsta_ack: got %b want 10", {a_p0_ack, a_p1_ack}); end
    next_cycle();
    idle_inputs();
  endtask
  task automatic test_drop_in_access();
    do_reset();
    p1_req = 1; p1_addr = 11'h005;
    @(negedge clk);
    n_checks++; if (a_en !== 1'b1) begin n_errors++; $display("FAIL drop_issue: en got %b want 1", a_en); end
    next_cycle();
    p1_req = 0;
    @(negedge clk);
    n_checks++; if (a_p1_ack !== 1'b1) begin n_errors++; $display("FAIL drop_ack: got %b want 1", a_p1_ack); end
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      @(negedge clk);
      n_checks++; if ({a_en, a_p1_ack, a_busy} !== 3'b000) begin n_errors++; $display("FAIL drop_after c%0d: en/ack/busy got %b want 000", c, {a_en, a_p1_ack, a_busy}); end
    end
    next_cycle();
  endtask
  // Requesters obey the hold-until-ack rule; the model tracks one access in flight
  task automatic test_random(input int inst);
    bit rr = (inst == 0);
    bit m_busy = 0, m_owner = 0, m_last = 1, m_rd = 0, exp_known = 0;
    bit w, e0, e1, done0, done1, ewe;
    logic [DW-1:0] exp_rd, ewd;
    logic [AW-1:0] ea;
    logic [3:0] ei;
    logic [DW-1:0] ref_mem [16];
    bit known [16];
    logic en, we, ack0, ack1, stall, bsy;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, rd;
    for (int i = 0; i < 16; i++) known[i] = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      en = inst != 0 ? b_en : a_en;
      we = inst != 0 ? b_we : a_we;
      addr = inst != 0 ? b_addr : a_addr;
      wd = inst != 0 ? b_wdata : a_wdata;
      ack0 = inst != 0 ? b_p0_ack : a_p0_ack;
      ack1 = inst != 0 ? b_p1_ack : a_p1_ack;
      stall = inst != 0 ? b_stall : a_stall;
      bsy = inst != 0 ? b_busy : a_busy;
      e0 = 0; e1 = 0; done0 = 0; done1 = 0;
      if (m_busy) begin
        e0 = !m_owner; e1 = m_owner;
        rd = m_owner ? (inst != 0 ? b_p1_rdata : a_p1_rdata) : (inst != 0 ? b_p0_rdata : a_p0_rdata);
        if (m_rd && exp_known) begin
          n_checks++; if (rd !== exp_rd) begin n_errors++; $display("FAIL rnd%0d_rdata c%0d: got %h want %h", inst, c, rd, exp_rd); end
        end
        n_checks++; if (en !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_en_access c%0d: got %b want 0", inst, c, en); end
        m_last = m_owner; m_busy = 0; done0 = e0; done1 = e1;
      end else if (p0_req || p1_req) begin
        w = (p0_req && p1_req) ? (rr && !m_last) : p1_req;
        ewe = w ? p1_we : p0_we;
        ea = w ? p1_addr : p0_addr;
        ewd = w ? p1_wdata : p0_wdata;
        ei = ea[3:0];
        n_checks++; if (en !== 1'b1 || we !== ewe || addr !== ea) begin n_errors++; $display("FAIL rnd%0d_issue c%0d: en/we %b%b addr %h want 1%b %h", inst, c, en, we, addr, ewe, ea); end
        if (ewe) begin
          n_checks++; if (wd !== ewd) begin n_errors++; $display("FAIL rnd%0d_wdata c%0d: got %h want %h", inst, c, wd, ewd); end
          ref_mem[ei] = ewd; known[ei] = 1;
        end else begin
          exp_rd = ref_mem[ei]; exp_known = known[ei];
        end
        m_rd = !ewe; m_busy = 1; m_owner = w;
      end else begin
        n_checks++; if (en !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_en_idle c%0d: got %b want 0", inst, c, en); end
      end
      n_checks++; if ({ack0, ack1, bsy} !== {e0, e1, e0 | e1}) begin n_errors++; $display("FAIL rnd%0d_ack c%0d: ack0/ack1/busy got %b want %b", inst, c, {ack0, ack1, bsy}, {e0, e1, e0 | e1}); end
      n_checks++; if (stall !== (p0_req && !e0)) begin n_errors++; $display("FAIL rnd%0d_stall c%0d: got %b want %b", inst, c, stall, p0_req && !e0); end
      next_cycle();
      if (done0 || !p0_req) begin
        p0_req = $urandom_range(0, 2) != 0; p0_we = 1'($urandom_range(0, 1));
        p0_addr = AW'($urandom_range(0, 15)); p0_wdata = $urandom;
      end
      if (done1 || !p1_req) begin
        p1_req = $urandom_range(0, 2) != 0; p1_we = 1'($urandom_range(0, 1));
        p1_addr = AW'($urandom_range(0, 15)); p1_wdata = $urandom;
      end
    end
    idle_inputs();
  endtask
  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_contention();
    test_back_to_back();
    test_reset_in_access();
    test_drop_in_access();
    test_random(0);
    test_random(1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
